// File: rtl/cmd_router.sv
// rtl/cmd_router.sv - table-driven command decoder routing payloads to ready/valid channels with per-command response byte
module cmd_router #(
    parameter int                        NUM_CHANNELS      = 4,
    parameter int                        MAX_PAYLOAD_BYTES = 32,
    parameter logic [NUM_CHANNELS*8-1:0] CH_OPCODES        = {8'hB0, 8'hA1, 8'hA0, 8'h00},
    parameter logic [NUM_CHANNELS*8-1:0] CH_LENGTHS        = {8'd17, 8'd30, 8'd1, 8'd0},
    parameter int                        TIMEOUT_CYCLES    = 1024
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           cmd_in_valid,
    output logic                           cmd_in_ready,
    input  logic [7:0]                     cmd_in_data,
    output logic                           cmd_out_valid,
    input  logic                           cmd_out_ready,
    output logic [7:0]                     cmd_out_data,
    output logic [NUM_CHANNELS-1:0]        ch_out_valid,
    input  logic [NUM_CHANNELS-1:0]        ch_out_ready,
    output logic [8*MAX_PAYLOAD_BYTES-1:0] ch_out_data,
    output logic [7:0]                     ch_out_len,
    output logic [15:0]                    err_count
);

    localparam int DW = 8 * MAX_PAYLOAD_BYTES;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

    localparam logic [7:0] RSP_UNKNOWN = 8'hEE;
    localparam logic [7:0] RSP_TIMEOUT = 8'hE1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_DELIVER,
        ST_RESPOND
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_CHANNELS-1:0] sel_q, sel_d;
    logic [7:0]              op_q, op_d;
    logic [7:0]              left_q, left_d;
    logic [7:0]              len_q, len_d;
    logic [DW-1:0]           asm_q, asm_d;
    logic [7:0]              resp_q, resp_d;
    logic [15:0]             err_q, err_d;
    logic [TW-1:0]           tmo_q, tmo_d;

    logic                    hit;
    logic [NUM_CHANNELS-1:0] hit_oh;
    logic [7:0]              hit_len;
    logic                    tmo_hit;
    logic                    in_fire;
    logic [15:0]             err_inc;

    // Timeout is judged on the registered counter so ready never depends on a same-cycle input.
    assign tmo_hit       = (TIMEOUT_CYCLES != 0) && (state_q == ST_PAYLOAD) && (tmo_q == TMO_LIMIT);
    assign cmd_in_ready  = (state_q == ST_IDLE) || ((state_q == ST_PAYLOAD) && !tmo_hit);
    assign cmd_out_valid = (state_q == ST_RESPOND);
    assign ch_out_valid  = (state_q == ST_DELIVER) ? sel_q : '0;
    assign cmd_out_data  = resp_q;
    assign ch_out_data   = asm_q;
    assign ch_out_len    = len_q;
    assign err_count     = err_q;
    assign in_fire       = cmd_in_valid && cmd_in_ready;
    assign err_inc       = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;

    always_comb begin
        hit     = 1'b0;
        hit_oh  = '0;
        hit_len = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!hit && (cmd_in_data == CH_OPCODES[8*i +: 8])) begin
                hit        = 1'b1;
                hit_oh[i]  = 1'b1;
                hit_len    = CH_LENGTHS[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        op_d    = op_q;
        left_d  = left_q;
        len_d   = len_q;
        asm_d   = asm_q;
        resp_d  = resp_q;
        err_d   = err_q;
        tmo_d   = tmo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    op_d  = cmd_in_data;
                    tmo_d = '0;
                    if (!hit) begin
                        resp_d  = RSP_UNKNOWN;
                        err_d   = err_inc;
                        state_d = ST_RESPOND;
                    end else begin
                        sel_d   = hit_oh;
                        len_d   = hit_len;
                        left_d  = hit_len;
                        asm_d   = '0;
                        state_d = (hit_len == 8'd0) ? ST_DELIVER : ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (tmo_hit) begin
                    asm_d   = '0;
                    resp_d  = RSP_TIMEOUT;
                    err_d   = err_inc;
                    state_d = ST_RESPOND;
                end else if (in_fire) begin
                    asm_d       = asm_q << 8;
                    asm_d[7:0]  = cmd_in_data;
                    left_d      = left_q - 8'd1;
                    tmo_d       = '0;
                    if (left_q == 8'd1) begin
                        state_d = ST_DELIVER;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_DELIVER: begin
                if (|(ch_out_ready & sel_q)) begin
                    resp_d  = op_q;
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (cmd_out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            op_q    <= '0;
            left_q  <= '0;
            len_q   <= '0;
            asm_q   <= '0;
            resp_q  <= '0;
            err_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            op_q    <= op_d;
            left_q  <= left_d;
            len_q   <= len_d;
            asm_q   <= asm_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_cmd_router.sv
// tb/tb_cmd_router.sv - directed scoreboard bench for cmd_router (timeout shortened to 8 cycles)
module tb_cmd_router;

    localparam int NCH = 4;
    localparam int DW  = 256;

    logic            clk = 1'b0;
    logic            rstn = 1'b1;
    logic            cmd_in_valid = 1'b0;
    logic            cmd_in_ready;
    logic [7:0]      cmd_in_data = 8'h00;
    logic            cmd_out_valid;
    logic            cmd_out_ready = 1'b1;
    logic [7:0]      cmd_out_data;
    logic [NCH-1:0]  ch_out_valid;
    logic [NCH-1:0]  ch_out_ready = '1;
    logic [DW-1:0]   ch_out_data;
    logic [7:0]      ch_out_len;
    logic [15:0]     err_count;

    cmd_router #(
        .NUM_CHANNELS(4),
        .MAX_PAYLOAD_BYTES(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .cmd_in_valid(cmd_in_valid),
        .cmd_in_ready(cmd_in_ready),
        .cmd_in_data(cmd_in_data),
        .cmd_out_valid(cmd_out_valid),
        .cmd_out_ready(cmd_out_ready),
        .cmd_out_data(cmd_out_data),
        .ch_out_valid(ch_out_valid),
        .ch_out_ready(ch_out_ready),
        .ch_out_data(ch_out_data),
        .ch_out_len(ch_out_len),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] oh;
        logic [7:0]     len;
        logic [DW-1:0]  data;
    } ch_exp_t;

    ch_exp_t    exp_ch[$];
    logic [7:0] exp_rsp[$];
    ch_exp_t    ce;
    logic [7:0] re;
    int         n_cmp = 0;
    int         n_err = 0;
    int         w;
    logic [DW-1:0] exp_b0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output int waited);
        logic acc;
        cmd_in_valid = 1'b1;
        cmd_in_data  = b;
        for (waited = 0; waited < 60; waited++) begin
            @(negedge clk);
            acc = cmd_in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (waited == 60) check("send_timeout", 256'(waited), 256'(0));
        cmd_in_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int dummy;
        send_byte(b, dummy);
    endtask

    task automatic drain(input string tag);
        int n;
        for (n = 0; n < 60; n++) begin
            @(negedge clk);
            if (exp_ch.size() == 0 && exp_rsp.size() == 0) break;
        end
        if (n == 60) check(tag, 256'(exp_ch.size() + exp_rsp.size()), 256'(0));
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  256'(cmd_in_ready),  256'(1));
        check({tag, "_out_valid"}, 256'(cmd_out_valid), 256'(0));
        check({tag, "_out_data"},  256'(cmd_out_data),  256'(0));
        check({tag, "_ch_valid"},  256'(ch_out_valid),  256'(0));
        check({tag, "_ch_data"},   ch_out_data,         256'(0));
        check({tag, "_ch_len"},    256'(ch_out_len),    256'(0));
        check({tag, "_err"},       256'(err_count),     256'(0));
    endtask

    // Scoreboard: every channel or response handshake consumes the oldest expectation.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (|(ch_out_valid & ch_out_ready)) begin
                if (exp_ch.size() == 0) begin
                    check("ch_spurious", 256'(ch_out_valid), 256'(0));
                end else begin
                    ce = exp_ch.pop_front();
                    check("ch_valid", 256'(ch_out_valid), 256'(ce.oh));
                    check("ch_len",   256'(ch_out_len),   256'(ce.len));
                    check("ch_data",  ch_out_data,        ce.data);
                end
            end
            if (cmd_out_valid && cmd_out_ready) begin
                if (exp_rsp.size() == 0) begin
                    check("rsp_spurious", 256'(cmd_out_valid), 256'(0));
                end else begin
                    re = exp_rsp.pop_front();
                    check("rsp_data", 256'(cmd_out_data), 256'(re));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst0");
        tick();
        rstn = 1'b1;
        tick();

        // Single-byte payload with all readys high, plus latency of each stage.
        exp_ch.push_back('{4'b0010, 8'd1, 256'h07});
        exp_rsp.push_back(8'hA0);
        send(8'hA0);
        send(8'h07);
        @(negedge clk);
        check("a0_deliver_next_cycle", 256'(ch_out_valid), 256'(4'b0010));
        check("a0_in_ready_low",       256'(cmd_in_ready), 256'(0));
        tick();
        @(negedge clk);
        check("a0_respond_next_cycle", 256'(cmd_out_valid), 256'(1));
        check("a0_ch_valid_dropped",   256'(ch_out_valid),  256'(0));
        tick();
        @(negedge clk);
        check("a0_idle_after_resp",    256'(cmd_in_ready),  256'(1));
        tick();

        // 17-byte payload stalled on channel 3 while other channel readys are high.
        exp_b0 = '0;
        for (int k = 1; k <= 17; k++) exp_b0[8*(17-k) +: 8] = 8'(k);
        exp_ch.push_back('{4'b1000, 8'd17, exp_b0});
        exp_rsp.push_back(8'hB0);
        ch_out_ready = 4'b0111;
        send(8'hB0);
        for (int k = 1; k <= 17; k++) send(8'(k));
        exp_ch.push_back('{4'b0001, 8'd0, 256'h0});
        exp_rsp.push_back(8'h00);
        cmd_in_valid = 1'b1;
        cmd_in_data  = 8'h00;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("b0_stall_valid", 256'(ch_out_valid), 256'(4'b1000));
            check("b0_stall_data",  ch_out_data,         exp_b0);
            check("b0_stall_ready", 256'(cmd_in_ready),  256'(0));
            tick();
        end
        cmd_out_ready = 1'b0;
        ch_out_ready  = 4'b1111;
        tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rsp_hold_valid", 256'(cmd_out_valid), 256'(1));
            check("rsp_hold_data",  256'(cmd_out_data),  256'(8'hB0));
            check("rsp_hold_ready", 256'(cmd_in_ready),  256'(0));
            tick();
        end
        cmd_out_ready = 1'b1;
        send_byte(8'h00, w);

        // Unknown opcode.
        exp_rsp.push_back(8'hEE);
        send(8'h5C);
        drain("drain_unknown");
        check("err_after_unknown", 256'(err_count), 256'(1));

        // Timeout boundary: gap of 7 survives, gap of 8 aborts.
        exp_rsp.push_back(8'hE1);
        send(8'hA1);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        repeat (7) tick();
        send_byte(8'h44, w);
        check("gap_7_accepted", 256'(w), 256'(0));
        repeat (7) tick();
        @(negedge clk);
        check("ready_at_count_7", 256'(cmd_in_ready), 256'(1));
        tick();
        exp_ch.push_back('{4'b0010, 8'd1, 256'h07});
        exp_rsp.push_back(8'hA0);
        cmd_in_valid = 1'b1;
        cmd_in_data  = 8'hA0;
        @(negedge clk);
        check("ready_at_count_8", 256'(cmd_in_ready), 256'(0));
        tick();
        send(8'hA0);
        send(8'h07);
        drain("drain_timeout");
        check("err_after_timeout", 256'(err_count), 256'(2));

        // Reset in the middle of an A1 payload drops it silently.
        send(8'hA1);
        for (int k = 0; k < 5; k++) send(8'(8'h60 + k));
        rstn = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        tick();
        rstn = 1'b1;
        tick();
        exp_ch.push_back('{4'b0010, 8'd1, 256'h07});
        exp_rsp.push_back(8'hA0);
        send(8'hA0);
        send(8'h07);
        drain("drain_after_reset");
        check("err_after_reset", 256'(err_count), 256'(0));
        check("ch_queue_empty", 256'(exp_ch.size()), 256'(0));
        check("rsp_queue_empty", 256'(exp_rsp.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
